wf_neopixel_framebuf: RTL and testbench

//  Double-buffered pixel store feeding the neopixel serial driver's RAM read port.

---
 rtl/wf_neopixel_framebuf.sv | 172 +++++++++++++++++
 tb/tb_wf_neopixel_framebuf.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wf_neopixel_framebuf.sv
// Double-buffered neopixel frame store with tear-free bank swap, brightness scaling and bit reversal.
// Optional gamma-2.2 output stage is enabled by defining WF_NEOPIXEL_GAMMA_EN (adds one pipeline stage).
module wf_neopixel_framebuf #(
   parameter int          NUM_OF_PIXELS = 8,
   parameter logic [7:0]  BRIGHT_RST    = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [7:0]  wr_addr,
   input  logic [23:0] wr_rgb,
   input  logic        frame_commit,
   input  logic        bright_we,
   input  logic [7:0]  bright_in,
   input  logic [7:0]  ram_rd_addr,
   output logic [23:0] ram_rd_data,
   output logic        commit_pend,
   output logic        frame_done,
   output logic        wr_addr_err
);

   localparam int         AW   = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
   localparam logic [8:0] NPIX = 9'(NUM_OF_PIXELS);

   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
      logic [16:0] p;
      p = {9'd0, c} * ({9'd0, b} + 17'd1);
      return p[15:8];
   endfunction

   function automatic logic [23:0] bit_rev(input logic [23:0] w);
      logic [23:0] r;
      for (int i = 0; i < 24; i++) begin
         r[i] = w[23-i];
      end
      return r;
   endfunction

   logic [23:0] bank0_mem [2**AW];
   logic [23:0] bank1_mem [2**AW];

   logic        bank_sel_q, bank_sel_d;
   logic        commit_pend_q, commit_pend_d;
   logic        frame_done_q, frame_done_d;
   logic        wr_addr_err_q, wr_addr_err_d;
   logic [7:0]  bright_q, bright_d;
   logic        shown_q, shown_d;
   logic        rd_nz_q, rd_nz_d;
   logic [23:0] rd_word_q, rd_word_d;
   logic [23:0] grb_q, grb_d;
   logic [23:0] out_grb;

   logic        wr_fire;
   logic        wr_store;
   logic        frame_end;
   logic        swap;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;

   assign wr_idx    = wr_addr[AW-1:0];
   assign rd_idx    = ram_rd_addr[AW-1:0];
   assign wr_ready  = ~commit_pend_q;
   assign wr_fire   = wr_valid & wr_ready;
   assign wr_store  = wr_fire & ({1'b0, wr_addr} < NPIX);
   // Frame end: driver address fell back to the idle value 0 after transmitting.
   assign frame_end = rd_nz_q & ~(|ram_rd_addr);
   assign swap      = frame_end & (commit_pend_q | frame_commit);

   always_comb begin
      bank_sel_d    = bank_sel_q;
      commit_pend_d = commit_pend_q;
      shown_d       = shown_q;
      bright_d      = bright_q;
      frame_done_d  = swap;
      wr_addr_err_d = wr_fire & ~wr_store;
      rd_nz_d       = |ram_rd_addr;
      if (swap) begin
         bank_sel_d    = ~bank_sel_q;
         commit_pend_d = 1'b0;
         shown_d       = 1'b1;
      end else if (frame_commit) begin
         commit_pend_d = 1'b1;
      end
      if (bright_we) begin
         bright_d = bright_in;
      end
   end

   always_comb begin
      rd_word_d = 24'd0;
      if ({1'b0, ram_rd_addr} < NPIX) begin
         rd_word_d = bank_sel_q ? bank1_mem[rd_idx] : bank0_mem[rd_idx];
      end
      grb_d = {scale(rd_word_q[15:8], bright_q),
               scale(rd_word_q[23:16], bright_q),
               scale(rd_word_q[7:0], bright_q)};
   end

   // Pixel storage is intentionally not reset; the host rewrites every pixel per frame.
   always_ff @(posedge clk) begin
      if (wr_store) begin
         if (bank_sel_q) begin
            bank0_mem[wr_idx] <= wr_rgb;
         end else begin
            bank1_mem[wr_idx] <= wr_rgb;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bank_sel_q    <= 1'b0;
         commit_pend_q <= 1'b0;
         frame_done_q  <= 1'b0;
         wr_addr_err_q <= 1'b0;
         bright_q      <= BRIGHT_RST;
         shown_q       <= 1'b0;
         rd_nz_q       <= 1'b0;
         rd_word_q     <= 24'd0;
         grb_q         <= 24'd0;
      end else begin
         bank_sel_q    <= bank_sel_d;
         commit_pend_q <= commit_pend_d;
         frame_done_q  <= frame_done_d;
         wr_addr_err_q <= wr_addr_err_d;
         bright_q      <= bright_d;
         shown_q       <= shown_d;
         rd_nz_q       <= rd_nz_d;
         rd_word_q     <= rd_word_d;
         grb_q         <= grb_d;
      end
   end

`ifdef WF_NEOPIXEL_GAMMA_EN
   // Truncating the curve reproduces the reference table endpoints (00->00, 80->37, FF->FF).
   function automatic logic [7:0] gamma_val(input int x);
      real y;
      y = 255.0 * $pow(real'(x) / 255.0, 2.2);
      return 8'($rtoi(y + 1.0e-6));
   endfunction

   logic [7:0]  gamma_rom [256];
   logic [23:0] gam_q, gam_d;

   for (genvar gi = 0; gi < 256; gi++) begin : g_gamma
      assign gamma_rom[gi] = gamma_val(gi);
   end

   always_comb begin
      gam_d = {gamma_rom[grb_q[23:16]], gamma_rom[grb_q[15:8]], gamma_rom[grb_q[7:0]]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gam_q <= 24'd0;
      end else begin
         gam_q <= gam_d;
      end
   end

   assign out_grb = gam_q;
`else
   assign out_grb = grb_q;
`endif

   assign ram_rd_data = shown_q ? bit_rev(out_grb) : 24'd0;
   assign commit_pend = commit_pend_q;
   assign frame_done  = frame_done_q;
   assign wr_addr_err = wr_addr_err_q;

endmodule

// File: tb/tb_wf_neopixel_framebuf.sv
// Directed self-checking bench for wf_neopixel_framebuf (default build: no gamma, read latency 2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_wf_neopixel_framebuf;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  wr_addr;
   logic [23:0] wr_rgb;
   logic        frame_commit;
   logic        bright_we;
   logic [7:0]  bright_in;
   logic [7:0]  ram_rd_addr;
   logic [23:0] ram_rd_data;
   logic        commit_pend;
   logic        frame_done;
   logic        wr_addr_err;

   int vectors     = 0;
   int miscompares = 0;

   wf_neopixel_framebuf #(.NUM_OF_PIXELS(8), .BRIGHT_RST(8'hFF)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_rgb       (wr_rgb),
      .frame_commit (frame_commit),
      .bright_we    (bright_we),
      .bright_in    (bright_in),
      .ram_rd_addr  (ram_rd_addr),
      .ram_rd_data  (ram_rd_data),
      .commit_pend  (commit_pend),
      .frame_done   (frame_done),
      .wr_addr_err  (wr_addr_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %06h expected %06h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] addr, input logic [23:0] rgb);
      wr_valid = 1'b1;
      wr_addr  = addr;
      wr_rgb   = rgb;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic commitFrame();
      frame_commit = 1'b1;
      tick();
      frame_commit = 1'b0;
   endtask

   task automatic setBright(input logic [7:0] b);
      bright_we = 1'b1;
      bright_in = b;
      tick();
      bright_we = 1'b0;
   endtask

   task automatic frameEnd(input string tag);
      ram_rd_addr = 8'd1;
      tick();
      ram_rd_addr = 8'd0;
      tick();
      checkOutput({tag, " frame_done"}, {23'd0, frame_done}, 24'd1);
      checkOutput({tag, " commit_pend"}, {23'd0, commit_pend}, 24'd0);
   endtask

   task automatic readPixel(input logic [7:0] addr, input logic [23:0] exp, input string tag);
      ram_rd_addr = addr;
      tick();
      tick();
      checkOutput(tag, ram_rd_data, exp);
      ram_rd_addr = 8'd0;
      tick();
   endtask

   initial begin
      reset        = 1'b1;
      wr_valid     = 1'b0;
      wr_addr      = 8'd0;
      wr_rgb       = 24'd0;
      frame_commit = 1'b0;
      bright_we    = 1'b0;
      bright_in    = 8'd0;
      ram_rd_addr  = 8'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("rst wr_ready", {23'd0, wr_ready}, 24'd1);
      checkOutput("rst commit_pend", {23'd0, commit_pend}, 24'd0);
      checkOutput("rst frame_done", {23'd0, frame_done}, 24'd0);
      checkOutput("rst wr_addr_err", {23'd0, wr_addr_err}, 24'd0);
      checkOutput("rst rd_data", ram_rd_data, 24'd0);
      @(negedge clk);

      // Frame with nothing written or committed: dark output, no swap
      for (int a = 1; a <= 8; a++) begin
         ram_rd_addr = 8'(a);
         tick();
         checkOutput("idle rd_data", ram_rd_data, 24'd0);
         checkOutput("idle frame_done", {23'd0, frame_done}, 24'd0);
      end
      ram_rd_addr = 8'd0;
      tick();
      checkOutput("idle end frame_done", {23'd0, frame_done}, 24'd0);
      tick();
      checkOutput("idle end2 frame_done", {23'd0, frame_done}, 24'd0);

      // First committed frame: red pixel 0
      applyStimulus(8'd0, 24'hFF0000);
      applyStimulus(8'd1, 24'h000011);
      commitFrame();
      checkOutput("commit pend", {23'd0, commit_pend}, 24'd1);
      checkOutput("commit wr_ready", {23'd0, wr_ready}, 24'd0);
      frameEnd("swap1");
      tick();
      checkOutput("swap1 pulse end", {23'd0, frame_done}, 24'd0);
      readPixel(8'd0, 24'h00FF00, "red px0");

      // Stalled write during pending commit lands in the new back bank
      applyStimulus(8'd0, 24'h00C800);
      applyStimulus(8'd1, 24'h0000AA);
      commitFrame();
      wr_valid = 1'b1;
      wr_addr  = 8'd0;
      wr_rgb   = 24'h123456;
      tick();
      checkOutput("stall wr_ready", {23'd0, wr_ready}, 24'd0);
      frameEnd("swap2");
      checkOutput("post swap wr_ready", {23'd0, wr_ready}, 24'd1);
      tick();
      wr_valid = 1'b0;
      readPixel(8'd0, 24'h000013, "swap2 px0");
      readPixel(8'd1, 24'h550000, "swap2 px1");
      commitFrame();
      frameEnd("swap3");
      readPixel(8'd0, 24'h6A482C, "stalled write px0");

      // Brightness scaling
      setBright(8'h7F);
      commitFrame();
      frameEnd("swap4");
      readPixel(8'd0, 24'h000026, "bright7F px0");
      readPixel(8'd1, 24'hAA0000, "bright7F px1");
      setBright(8'h00);
      readPixel(8'd0, 24'h000000, "bright00 px0");
      setBright(8'hFF);
      readPixel(8'd0, 24'h000013, "brightFF px0");

      // Out-of-range writes are dropped and flagged
      applyStimulus(8'd8, 24'hFFFFFF);
      checkOutput("addr8 err pulse", {23'd0, wr_addr_err}, 24'd1);
      tick();
      checkOutput("addr8 err clear", {23'd0, wr_addr_err}, 24'd0);
      applyStimulus(8'hFF, 24'hFFFFFF);
      checkOutput("addrFF err pulse", {23'd0, wr_addr_err}, 24'd1);
      applyStimulus(8'd2, 24'h010203);
      checkOutput("in-range no err", {23'd0, wr_addr_err}, 24'd0);
      readPixel(8'd8, 24'h000000, "read addr8");
      commitFrame();
      frameEnd("swap5");
      readPixel(8'd0, 24'h6A482C, "bank intact px0");
      readPixel(8'd1, 24'h880000, "bank intact px1");

      // Commit coincident with frame end swaps at once
      ram_rd_addr = 8'd1;
      tick();
      ram_rd_addr  = 8'd0;
      frame_commit = 1'b1;
      checkOutput("coinc pre pend", {23'd0, commit_pend}, 24'd0);
      tick();
      frame_commit = 1'b0;
      checkOutput("coinc frame_done", {23'd0, frame_done}, 24'd1);
      checkOutput("coinc commit_pend", {23'd0, commit_pend}, 24'd0);
      readPixel(8'd0, 24'h000013, "coinc px0");
      commitFrame();
      frameEnd("swap7");
      readPixel(8'd0, 24'h6A482C, "pre-reset px0");

      // Reset in the middle of a frame
      setBright(8'h7F);
      ram_rd_addr = 8'd3;
      tick();
      reset = 1'b1;
      #1;
      checkOutput("midrst rd_data", ram_rd_data, 24'd0);
      checkOutput("midrst wr_ready", {23'd0, wr_ready}, 24'd1);
      checkOutput("midrst frame_done", {23'd0, frame_done}, 24'd0);
      @(negedge clk);
      reset       = 1'b0;
      ram_rd_addr = 8'd0;
      tick();
      readPixel(8'd0, 24'h000000, "post-reset dark");
      commitFrame();
      frameEnd("swap8");
      readPixel(8'd0, 24'h6A482C, "post-reset bank/bright");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
